axi4_reg_mem_slave: RTL

//  AXI4 slave register memory: terminating endpoint on the slave modport of axi4_if.

---
 rtl/axi4_reg_mem_slave_pkg.sv | 50 +++++
 rtl/axi4_reg_mem_slave_if.sv | 54 +++++
 rtl/axi4_reg_mem_slave_addr_gen.sv | 27 ++
 rtl/axi4_reg_mem_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_reg_mem_slave_pkg.sv
// Shared types for the AXI4 register-memory slave: burst/response encodings,
// FSM state enums and the burst legality helpers used by both channels.
package axi4_reg_mem_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Bursts whose data must never touch the array.
  function automatic logic burst_drop(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst == BURST_RSVD);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    return burst_drop(size, burst) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // Illegal WRAP lengths and the reserved encoding walk the address like INCR.
  function automatic burst_t eff_burst(input logic [1:0] burst, input logic [7:0] len);
    burst_t b;
    b = burst_t'(burst);
    if (b == BURST_RSVD) b = BURST_INCR;
    if ((b == BURST_WRAP) && !wrap_len_ok(len)) b = BURST_INCR;
    return b;
  endfunction

endpackage

// File: rtl/axi4_reg_mem_slave_if.sv
// AXI4 bus bundle (32-bit address/data, 4-bit ID) with master and slave views.
// Every channel transfers on the rising edge where valid and ready are both high;
// a source holds valid and its payload unchanged until that edge, ready may toggle freely.
interface axi4_reg_mem_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_reg_mem_slave_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts of 32-bit beats.
module axi4_reg_mem_slave_addr_gen
  import axi4_reg_mem_slave_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  burst_t      burst_i,
  output logic [31:0] next_addr_o
);
  logic [31:0] base;
  logic [31:0] incr;
  logic [31:0] wrap_bytes;
  logic [31:0] wrap_mask;

  always_comb begin
    base       = addr_i & 32'hFFFF_FFFC;
    incr       = base + 32'd4;
    wrap_bytes = ({24'd0, len_i} + 32'd1) << 2;
    wrap_mask  = wrap_bytes - 32'd1;
    case (burst_i)
      BURST_FIXED: next_addr_o = base;
      // Keep the bits above the wrap window, roll the offset inside it.
      BURST_WRAP:  next_addr_o = (base & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr_o = incr;
    endcase
  end
endmodule

// File: rtl/axi4_reg_mem_slave.sv
// AXI4 slave backed by DEPTH x 32-bit registers; independent write and read FSMs,
// one outstanding burst per direction, SLVERR for out-of-range or illegal bursts.
module axi4_reg_mem_slave
  import axi4_reg_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  axi4_reg_mem_slave_if.slave  s_axi,
  output wr_state_t            wr_state_o,
  output rd_state_t            rd_state_o
);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] SPAN_MASK = 32'(DEPTH * 4 - 1);

  function automatic logic in_range(input logic [31:0] addr);
    return (addr & ~SPAN_MASK) == BASE_ADDR;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'(addr >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH];

  // Write channel state
  wr_state_t   wr_state_q;
  logic [3:0]  aw_id_q;
  logic [31:0] aw_addr_q;
  logic [7:0]  aw_len_q;
  burst_t      aw_burst_q;
  logic [7:0]  w_cnt_q;
  logic        w_drop_q;
  logic        w_err_q;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;

  // Read channel state
  rd_state_t   rd_state_q;
  logic [31:0] ar_addr_q;
  logic [7:0]  ar_len_q;
  burst_t      ar_burst_q;
  logic [7:0]  r_cnt_q;
  logic        r_drop_q;
  logic        r_err_q;
  logic        arready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [3:0]  rid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic [31:0] aw_next_addr;
  logic [31:0] ar_next_addr;

  axi4_reg_mem_slave_addr_gen u_wr_addr_gen (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (aw_next_addr)
  );

  axi4_reg_mem_slave_addr_gen u_rd_addr_gen (
    .addr_i      (ar_addr_q),
    .len_i       (ar_len_q),
    .burst_i     (ar_burst_q),
    .next_addr_o (ar_next_addr)
  );

  logic              w_fire;
  logic              w_last_beat;
  logic              w_addr_ok;
  logic              w_beat_err;
  logic              mem_we;
  logic [IDX_W-1:0]  w_idx;

  always_comb begin
    w_fire      = s_axi.wvalid && wready_q;
    w_last_beat = (w_cnt_q == aw_len_q);
    w_addr_ok   = in_range(aw_addr_q);
    w_idx       = word_idx(aw_addr_q);
    w_beat_err  = !w_addr_ok || (s_axi.wlast != w_last_beat);
    mem_we      = w_fire && w_addr_ok && !w_drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem_q[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= BURST_FIXED;
      w_cnt_q    <= '0;
      w_drop_q   <= 1'b0;
      w_err_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi.awvalid && awready_q) begin
            aw_id_q    <= s_axi.awid;
            aw_addr_q  <= s_axi.awaddr;
            aw_len_q   <= s_axi.awlen;
            aw_burst_q <= eff_burst(s_axi.awburst, s_axi.awlen);
            w_drop_q   <= burst_drop(s_axi.awsize, s_axi.awburst);
            w_err_q    <= burst_err(s_axi.awsize, s_axi.awburst, s_axi.awlen);
            w_cnt_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last_beat) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bid_q      <= aw_id_q;
              bresp_q    <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end else begin
              w_err_q   <= w_err_q || w_beat_err;
              w_cnt_q   <= w_cnt_q + 8'd1;
              aw_addr_q <= aw_next_addr;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  logic        r_fire;
  logic [31:0] r_load_addr;
  logic        r_load_ok;
  logic [31:0] r_load_data;
  logic        ar_drop;
  logic        ar_err;

  // The first beat loads from the incoming araddr, later beats from the generator.
  always_comb begin
    r_fire      = rvalid_q && s_axi.rready;
    r_load_addr = (rd_state_q == R_IDLE) ? s_axi.araddr : ar_next_addr;
    r_load_ok   = in_range(r_load_addr);
    r_load_data = r_load_ok ? mem_q[word_idx(r_load_addr)] : '0;
    ar_drop     = burst_drop(s_axi.arsize, s_axi.arburst);
    ar_err      = burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= BURST_FIXED;
      r_cnt_q    <= '0;
      r_drop_q   <= 1'b0;
      r_err_q    <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi.arvalid && arready_q) begin
            ar_addr_q  <= s_axi.araddr;
            ar_len_q   <= s_axi.arlen;
            ar_burst_q <= eff_burst(s_axi.arburst, s_axi.arlen);
            r_drop_q   <= ar_drop;
            r_err_q    <= ar_err;
            r_cnt_q    <= '0;
            rid_q      <= s_axi.arid;
            rdata_q    <= ar_drop ? '0 : r_load_data;
            rresp_q    <= (ar_err || !r_load_ok) ? RESP_SLVERR : RESP_OKAY;
            rlast_q    <= (s_axi.arlen == 8'd0);
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (r_cnt_q == ar_len_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              rd_state_q <= R_IDLE;
            end else begin
              ar_addr_q <= ar_next_addr;
              r_cnt_q   <= r_cnt_q + 8'd1;
              rdata_q   <= r_drop_q ? '0 : r_load_data;
              rresp_q   <= (r_err_q || !r_load_ok) ? RESP_SLVERR : RESP_OKAY;
              rlast_q   <= ((r_cnt_q + 8'd1) == ar_len_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign wr_state_o    = wr_state_q;
  assign rd_state_o    = rd_state_q;

endmodule
